// File: rtl/lane_map_reader_if.sv
// Lane map reader bus bundle: BRAM read port plus the row-result valid/ready stream.
// master = the reader (drives reads and results); slave = memory/host side.
interface lane_map_reader_if #(
  parameter int OUT_WIDTH  = 64,
  parameter int OUT_HEIGHT = 32,
  parameter int NUM_LANES  = 4
);
  localparam int CW = $clog2(OUT_WIDTH);
  localparam int RW = $clog2(OUT_HEIGHT);
  localparam int AW = $clog2(OUT_WIDTH * OUT_HEIGHT);
  localparam int LW = CW + 1;

  logic [AW-1:0]           bram_rd_addr;
  logic                    bram_rd_en;
  logic [7:0]              bram_rd_data;
  logic [NUM_LANES*LW-1:0] o_data;
  logic [RW-1:0]           o_row;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_last;

  modport master (
    output bram_rd_addr, bram_rd_en, o_data, o_row, o_valid, o_last,
    input  bram_rd_data, i_ready
  );

  modport slave (
    input  bram_rd_addr, bram_rd_en, o_data, o_row, o_valid, o_last,
    output bram_rd_data, i_ready
  );
endinterface

// File: rtl/lane_map_reader.sv
// Scans the per-pixel lane map row by row and emits, per lane, the lowest set column plus a present flag.
// Latency: OUT_WIDTH+2 cycles per row (W reads, 1 drain, 1 emit) with i_ready held high.
// Backpressure: result held in EMIT until o_valid && i_ready; no BRAM reads are issued while waiting.
module lane_map_reader #(
  parameter int OUT_WIDTH  = 64,
  parameter int OUT_HEIGHT = 32,
  parameter int NUM_LANES  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_busy,
  output logic o_done,
  lane_map_reader_if.master bus
);
  localparam int CW = $clog2(OUT_WIDTH);
  localparam int RW = $clog2(OUT_HEIGHT);
  localparam int LW = CW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t                  state_q;
  logic [RW-1:0]           row_q;
  logic [CW-1:0]           col_q;
  logic                    rd_en_q;
  logic [CW-1:0]           tag_q;
  logic                    tag_vld_q;
  logic [NUM_LANES-1:0]    pres_q, pres_d;
  logic [CW-1:0]           lcol_q [NUM_LANES];
  logic [CW-1:0]           lcol_d [NUM_LANES];
  logic [NUM_LANES*LW-1:0] data_q, data_d;
  logic                    valid_q, last_q, busy_q, done_q;

  // Fold the returned byte into the lane accumulators; first set column in a row wins.
  always_comb begin
    pres_d = pres_q;
    lcol_d = lcol_q;
    if (tag_vld_q) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.bram_rd_data[i] && !pres_q[i]) begin
          pres_d[i] = 1'b1;
          lcol_d[i] = tag_q;
        end
      end
    end
  end

  // Pack the updated accumulators into the output word, absent lanes read as all-zero.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      data_d[i*LW +: LW] = {pres_d[i], pres_d[i] ? lcol_d[i] : {CW{1'b0}}};
    end
  end

  // Read-data tag pipeline: column and strobe delayed to line up with the BRAM return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
    end else begin
      tag_q     <= col_q;
      tag_vld_q <= rd_en_q;
    end
  end

  // Frame sequencer with registered outputs and lane accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      rd_en_q <= 1'b0;
      pres_q  <= '0;
      lcol_q  <= '{default: '0};
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pres_q <= pres_d;
      lcol_q <= lcol_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= SCAN;
            row_q   <= '0;
            col_q   <= '0;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            pres_q  <= '0;
            lcol_q  <= '{default: '0};
          end
        end
        SCAN: begin
          if (rd_en_q) begin
            // Last column issued: next cycle is the drain for its return.
            if (col_q == CW'(OUT_WIDTH - 1)) rd_en_q <= 1'b0;
            col_q <= col_q + 1'b1;
          end else begin
            // Drain cycle: final byte is folded in via data_d.
            state_q <= EMIT;
            valid_q <= 1'b1;
            data_q  <= data_d;
            last_q  <= (row_q == RW'(OUT_HEIGHT - 1));
          end
        end
        EMIT: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (row_q == RW'(OUT_HEIGHT - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SCAN;
              row_q   <= row_q + 1'b1;
              col_q   <= '0;
              rd_en_q <= 1'b1;
              pres_q  <= '0;
              lcol_q  <= '{default: '0};
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Row and column are powers of two, so the address is a plain concatenation.
  assign bus.bram_rd_addr = {row_q, col_q};
  assign bus.bram_rd_en   = rd_en_q;
  assign bus.o_data       = data_q;
  assign bus.o_row        = row_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_last       = last_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
endmodule

// File: tb/tb_lane_map_reader.sv
// Bench for lane_map_reader: BRAM model plus per-row scoreboard computed from the lane map contents.
// Covers reset, diagonal/duplicate/boundary maps, random maps, backpressure, start-while-busy, mid-frame reset.
module tb_lane_map_reader;
  localparam int W   = 64;
  localparam int H   = 32;
  localparam int NL  = 4;
  localparam int CW  = $clog2(W);
  localparam int LW  = CW + 1;
  localparam int DW  = NL * LW;

  logic clk, rst_n, i_start, o_busy, o_done;
  logic [7:0] mem [W*H];
  logic [DW-1:0] got_data [H];
  int cyc, done_cnt, n_chk, n_pass, start_cyc, last_hs;

  lane_map_reader_if #(.OUT_WIDTH(W), .OUT_HEIGHT(H), .NUM_LANES(NL)) bus ();

  lane_map_reader #(.OUT_WIDTH(W), .OUT_HEIGHT(H), .NUM_LANES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_done) done_cnt <= done_cnt + 1;

  // One-cycle-latency BRAM.
  always @(posedge clk) if (bus.bram_rd_en) bus.bram_rd_data <= mem[bus.bram_rd_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: per lane, lowest column in the row whose lane bit is set.
  function automatic logic [DW-1:0] exp_row(input int r);
    logic [DW-1:0] e;
    e = '0;
    for (int l = 0; l < NL; l++) begin
      for (int c = W - 1; c >= 0; c--) begin
        if (mem[r*W + c][l]) e[l*LW +: LW] = {1'b1, 6'(c)};
      end
    end
    return e;
  endfunction

  task automatic fill_diag();
    for (int a = 0; a < W*H; a++) mem[a] = 8'($urandom_range(0, 15) << 4);
    for (int r = 0; r < H; r++) begin
      mem[r*W + r]           = mem[r*W + r] | 8'h01;
      mem[r*W + (W - 1 - r)] = mem[r*W + (W - 1 - r)] | 8'h02;
    end
    mem[5*W + 10] = mem[5*W + 10] | 8'h04;
    mem[5*W + 40] = mem[5*W + 40] | 8'h04;
    mem[5*W + 63] = mem[5*W + 63] | 8'h04;
    mem[0*W + 63] = mem[0*W + 63] | 8'h08;
    mem[31*W + 0] = mem[31*W + 0] | 8'h08;
  endtask

  task automatic fill_random();
    for (int a = 0; a < W*H; a++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 15) << 4);
      for (int l = 0; l < NL; l++) if ($urandom_range(0, 40) == 0) b[l] = 1'b1;
      if ((a / W) % 5 == 0) b[NL-1:0] = '0;
      mem[a] = b;
    end
  endtask

  task automatic run_frame(input bit bp, input bit pulse_start, input int abort_row);
    bit ok;
    int k;
    i_start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    i_start = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_rd_en", bus.bram_rd_en, 1);
    check("start_addr", bus.bram_rd_addr, 0);
    for (int r = 0; r < H; r++) begin
      if (r == abort_row) begin
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_rd_en", bus.bram_rd_en, 0);
        check("rst_addr", bus.bram_rd_addr, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_row", bus.o_row, 0);
        check("rst_data", bus.o_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      ok = 1'b0;
      for (int t = 0; t < 500; t++) begin
        if (bus.o_valid) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) begin
        check("valid_timeout", 0, 1);
        return;
      end
      got_data[r] = bus.o_data;
      check("row_data", bus.o_data, exp_row(r));
      check("row_idx", bus.o_row, r);
      check("row_last", bus.o_last, r == H - 1);
      check("emit_no_read", bus.bram_rd_en, 0);
      if (bp && r == 3) begin
        bus.i_ready = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          check("bp_valid", bus.o_valid, 1);
          check("bp_data", bus.o_data, exp_row(3));
          check("bp_row", bus.o_row, 3);
          check("bp_no_read", bus.bram_rd_en, 0);
        end
        bus.i_ready = 1'b1;
      end else if (bp) begin
        bus.i_ready = 1'b0;
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin @(posedge clk); #1; end
        bus.i_ready = 1'b1;
      end
      @(posedge clk); #1;
      last_hs = cyc;
      if (pulse_start) i_start = (r == 1 || r == 2);
      if (bp && r == 3) begin
        check("row4_scan_en", bus.bram_rd_en, 1);
        check("row4_scan_addr", bus.bram_rd_addr, 4 * W);
      end
    end
    check("done_pulse", o_done, 1);
    check("done_busy", o_busy, 1);
    @(posedge clk); #1;
    check("done_drop", o_done, 0);
    check("idle_busy", o_busy, 0);
  endtask

  initial begin
    int dc;
    cyc = 0; done_cnt = 0; n_chk = 0; n_pass = 0;
    rst_n = 1'b1; i_start = 1'b0; bus.i_ready = 1'b1; bus.bram_rd_data = '0;
    #2 rst_n = 1'b0;
    i_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr", bus.bram_rd_addr, 0);
    check("reset_rd_en", bus.bram_rd_en, 0);
    check("reset_data", bus.o_data, 0);
    check("reset_row", bus.o_row, 0);
    check("reset_valid", bus.o_valid, 0);
    check("reset_last", bus.o_last, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    rst_n = 1'b1;
    i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("idle_no_start", o_busy, 0);

    // Diagonal / duplicate / boundary map, i_ready held high.
    fill_diag();
    run_frame(1'b0, 1'b0, -1);
    check("frame_cycles", last_hs - start_cyc, H * (W + 2));
    check("diag_row0_lane0", got_data[0][0 +: LW], 7'h40);
    check("diag_row9_lane1", got_data[9][LW +: LW], {1'b1, 6'(W - 1 - 9)});
    check("dup_row5_lane2", got_data[5][2*LW +: LW], {1'b1, 6'd10});
    check("bound_row0_lane3", got_data[0][3*LW +: LW], {1'b1, 6'd63});
    check("bound_row31_lane3", got_data[31][3*LW +: LW], {1'b1, 6'd0});
    check("empty_row7_lane2", got_data[7][2*LW +: LW], 0);

    // Random map with backpressure and i_start pulsed while busy.
    fill_random();
    dc = done_cnt;
    run_frame(1'b1, 1'b1, -1);
    repeat (30) @(posedge clk);
    #1;
    check("single_done", done_cnt - dc, 1);
    check("start_ignored", o_busy, 0);

    // Reset in the middle of row 7, then a fresh frame.
    fill_random();
    run_frame(1'b0, 1'b0, 7);
    repeat (5) @(posedge clk);
    #1 check("no_resume", o_busy, 0);
    run_frame(1'b0, 1'b0, -1);
    check("frame_cycles_2", last_hs - start_cyc, H * (W + 2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lane_map_reader.md
# lane_map_reader

Reads the lane map that post-processing writes into BRAM (one byte per pixel, bit i = lane i present) and compresses it back into per-row lane coordinates. For every row it emits, per lane, the lowest column whose lane bit is set plus a present flag. Output uses a valid/ready handshake towards the result/host interface. Sits on the BRAM read port, downstream of post-processing and gated by its frame-valid output.

## Interface
- OUT_WIDTH, 64, columns per row (power of two)
- OUT_HEIGHT, 32, rows per frame (power of two)
- NUM_LANES, 4, lane bits used per byte (1..8)
- Derived: CW = $clog2(OUT_WIDTH), RW = $clog2(OUT_HEIGHT), AW = $clog2(OUT_WIDTH*OUT_HEIGHT), LW = CW+1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  frame ready; sampled only in IDLE
- bram_rd_addr  out  AW  row*OUT_WIDTH + col
- bram_rd_en  out  1  read strobe; data returns exactly 1 cycle later
- bram_rd_data  in  8  pixel byte; bits [NUM_LANES-1:0] used, rest ignored
- o_data  out  NUM_LANES*LW  lane i at [(i+1)*LW-1 : i*LW] = {present, col[CW-1:0]}
- o_row  out  RW  row index of o_data
- o_valid  out  1  o_data/o_row/o_last valid
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_last  out  1  high with last row (row OUT_HEIGHT-1)
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse after last row handshake

## Operation
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE: i_start=1 -> SCAN, row=0, col=0, lane accumulators cleared.
- SCAN: issue reads col 0..OUT_WIDTH-1 on consecutive cycles (bram_rd_en=1), then one drain cycle (bram_rd_en=0) for final return; then -> EMIT.
- Capture: returned byte tagged with delayed column (1-cycle pipeline of col and rd_en). For lane i, if bit i set and lane not yet present: present<=1, col<=tag. Later set bits in the same row ignored (lowest column wins).
- Lane with no set bit in row: present=0, col=0.
- EMIT: o_valid=1; o_data/o_row/o_last held stable until handshake. On handshake: row<OUT_HEIGHT-1 -> row+1, clear accumulators, SCAN; row=OUT_HEIGHT-1 -> DONE.
- DONE: o_done=1 for one cycle -> IDLE.
- i_start ignored outside IDLE; no queuing.
- Row and column counters wrap to 0 at limit; address never exceeds OUT_WIDTH*OUT_HEIGHT-1.

## Timing
- Reset values: bram_rd_addr=0, bram_rd_en=0, o_data=0, o_row=0, o_valid=0, o_last=0, o_busy=0, o_done=0; FSM=IDLE.
- Cycle T: i_start sampled high in IDLE. T+1: first read (col 0), o_busy=1.
- Reads at T+1..T+OUT_WIDTH; drain T+OUT_WIDTH+1; o_valid first high at T+OUT_WIDTH+2.
- Per row with i_ready held high: OUT_WIDTH+2 cycles (W reads, 1 drain, 1 EMIT). Full frame: OUT_HEIGHT*(OUT_WIDTH+2) cycles to last handshake; o_done the following cycle; o_busy drops with o_done going low (IDLE).
- Backpressure: o_valid never drops without handshake; no reads issued while in EMIT.
- Reset mid-frame: immediate return to reset values; any partial row discarded; next frame requires new i_start.
- o_data accumulators update only on returned data cycles; a byte returned on the drain cycle (col OUT_WIDTH-1) is included in that row.

## Test plan
- Reset: hold rst_n low, drive i_start=1 -> all outputs 0; release, no i_start -> o_busy stays 0.
- Diagonal map: lane0 bit at col=row, lane1 at col=63-row, lanes2/3 empty -> row r gives lane0 {1,r}, lane1 {1,63-r}, lanes2/3 {0,0}; 32 rows, o_last only on row 31, o_done 1 cycle after; 2112 cycles start-to-last-handshake with i_ready=1.
- Duplicates: row 5 lane2 bits at cols 10, 40, 63 -> lane2 {1,10}; bits in [7:NUM_LANES] set -> no effect.
- Boundary columns: lane3 only at col 63 row 0 and col 0 row 31 -> {1,63} and {1,0}.
- Backpressure: i_ready low 10 cycles during row 3 EMIT -> o_valid, o_data, o_row stable, bram_rd_en=0 throughout; row 4 scan starts cycle after handshake.
- i_start pulsed while busy -> ignored, single o_done; rst_n asserted mid-row 7 -> outputs 0 next cycle, new i_start restarts at row 0.
